// File: rtl/disp_arbiter_pkg.sv
// disp_arbiter_pkg: shared constants, the arbiter state type and a small
// index-to-one-hot helper used by the display arbiter.
package disp_arbiter_pkg;

    localparam int unsigned N_REQ  = 4;  // number of requesters
    localparam int unsigned CODE_W = 3;  // width of one display code
    localparam int unsigned IDX_W  = 2;  // width of a requester index
    localparam int unsigned HOLD_W = 8;  // hold counter width (HOLD_TICKS up to 255)

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/disp_arbiter_if.sv
// disp_arbiter_if: request/display bundle between requesters and the arbiter.
//   req      requester request levels, bit i = requester i
//   val      packed requester codes, val[3i+2:3i] = requester i
//   disp_val code shown on the 7-segment decoder
//   grant    one-hot grant, zero when idle
//   ack      one-cycle completion pulse per requester
//   busy     high while a slot is being shown
//   tick     prescaler heartbeat pulse
// Modports: master = requester side, slave = arbiter side.
interface disp_arbiter_if;
    import disp_arbiter_pkg::*;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*CODE_W-1:0] val;
    logic [CODE_W-1:0]       disp_val;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        ack;
    logic                    busy;
    logic                    tick;

    modport master (
        output req, val,
        input  disp_val, grant, ack, busy, tick
    );

    modport slave (
        input  req, val,
        output disp_val, grant, ack, busy, tick
    );

endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running DIV_BITS-bit counter producing a one-cycle
// tick whenever the counter is all-ones (one tick every 2^DIV_BITS clocks).
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset, clears the counter
//   tick   wrap pulse
module tick_prescaler #(
    parameter int unsigned DIV_BITS = 26
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [DIV_BITS-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = &cnt_q;

endmodule

// File: rtl/disp_arbiter.sv
// disp_arbiter: shares one 7-segment display among four requesters. An idle
// cycle picks a winner (round-robin by default), latches its code and shows
// it for HOLD_TICKS prescaler ticks, pulsing ack on completion. A dropped
// request aborts the slot without ack. At least one idle cycle separates slots.
//   CLOCK_50  clock, rising edge
//   RESET_N   synchronous active-low reset
//   bus       disp_arbiter_if slave: req/val in, disp_val/grant/ack/busy/tick out
// Build option: define DISP_ARBITER_FIXED_PRIO_EN for strict fixed priority
// (requester 0 highest, no round-robin pointer).
module disp_arbiter
    import disp_arbiter_pkg::*;
#(
    parameter int unsigned       DIV_BITS   = 26,
    parameter int unsigned       HOLD_TICKS = 2,
    parameter logic [CODE_W-1:0] IDLE_CODE  = 3'b111
) (
    input logic           CLOCK_50,
    input logic           RESET_N,
    disp_arbiter_if.slave bus
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    logic                         tick;
    state_e                       state_q, state_d;
    logic [N_REQ-1:0]             grant_q, grant_d;
    logic [CODE_W-1:0]            code_q, code_d;
    logic [HOLD_W-1:0]            hold_q, hold_d;
    logic [IDX_W-1:0]             win_idx;
    logic                         slot_done;
    logic [N_REQ-1:0][CODE_W-1:0] vals;
`ifndef DISP_ARBITER_FIXED_PRIO_EN
    logic [IDX_W-1:0]             ptr_q, ptr_d;
`endif

    assign vals = bus.val;

    tick_prescaler #(
        .DIV_BITS(DIV_BITS)
    ) u_prescaler (
        .clk  (CLOCK_50),
        .rst_n(RESET_N),
        .tick (tick)
    );

    // Winner selection; only meaningful while some req bit is set.
    always_comb begin
        win_idx = '0;
`ifdef DISP_ARBITER_FIXED_PRIO_EN
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) win_idx = IDX_W'(i);
        end
`else
        // Scan from farthest to nearest so the first requester after ptr_q wins;
        // k = N_REQ wraps back onto ptr_q itself, the lowest-priority slot.
        for (int k = N_REQ; k >= 1; k--) begin
            if (bus.req[ptr_q + IDX_W'(k)]) win_idx = ptr_q + IDX_W'(k);
        end
`endif
    end

    // Completion takes precedence over a same-cycle request drop.
    assign slot_done = (state_q == ST_SHOW) && tick && (hold_q == HOLD_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            code_q  <= IDLE_CODE;
            hold_q  <= '0;
`ifndef DISP_ARBITER_FIXED_PRIO_EN
            ptr_q   <= IDX_W'(N_REQ - 1);
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            code_q  <= code_d;
            hold_q  <= hold_d;
`ifndef DISP_ARBITER_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        code_d  = code_q;
        hold_d  = hold_q;
`ifndef DISP_ARBITER_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_d = ST_SHOW;
                    grant_d = idx_to_onehot(win_idx);
                    code_d  = vals[win_idx];
                    hold_d  = '0;
`ifndef DISP_ARBITER_FIXED_PRIO_EN
                    // Pointer moves at grant time, so an aborted slot still advances it.
                    ptr_d   = win_idx;
`endif
                end
            end
            ST_SHOW: begin
                if (slot_done || !(|(bus.req & grant_q))) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (tick) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        bus.busy     = (state_q == ST_SHOW);
        bus.grant    = grant_q;
        bus.disp_val = (state_q == ST_SHOW) ? code_q : IDLE_CODE;
        bus.ack      = slot_done ? grant_q : '0;
        bus.tick     = tick;
    end

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter DIV_BITS, default 26: prescaler width; one tick every 2^DIV_BITS clocks.
REQ-002 Parameter HOLD_TICKS, default 2: ticks a granted value stays on the display (1..255).
REQ-003 Parameter IDLE_CODE, default 3'b111: display code when no requester is served.
REQ-004 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-005 RESET_N  in  1  synchronous, active-low reset.
REQ-006 req  in  4  per-requester request level, bit i = requester i.
REQ-007 val  in  12  requester values, val[3i+2:3i] = 3-bit code of requester i.
REQ-008 disp_val  out  3  code to the 7-segment decoder.
REQ-009 grant  out  4  one-hot grant; all-zero when idle.
REQ-010 ack  out  4  one-cycle pulse on bit i when requester i's slot completes.
REQ-011 busy  out  1  high while in SHOW.
REQ-012 tick  out  1  one-cycle prescaler wrap pulse, for LED heartbeat.

Function
REQ-013 Prescaler: DIV_BITS-bit free-running counter; tick high in the cycle the counter equals all-ones.
REQ-014 States: IDLE and SHOW; no other states reachable.
REQ-015 IDLE, req != 0: winner picked combinationally; next cycle state=SHOW, grant=winner, disp_val=val of winner latched, hold counter=0.
REQ-016 Arbitration round-robin: search starts at last-granted index +1 mod 4; after reset the pointer is 3, so requester 0 wins first.
REQ-017 IDLE, req == 0: grant=0, disp_val=IDLE_CODE, busy=0.
REQ-018 SHOW: hold counter increments on each tick; disp_val stays frozen even if val changes.
REQ-019 SHOW, counter reaches HOLD_TICKS: the same-cycle ack bit of the granted requester pulses; next cycle state=IDLE, grant=0.
REQ-020 SHOW, granted requester's req drops before completion: next cycle state=IDLE, no ack, pointer still advances.
REQ-021 Req drop and completion in the same cycle: completion wins, ack pulses.
REQ-022 Minimum one IDLE cycle between slots, where disp_val=IDLE_CODE; back-to-back grants forbidden.
REQ-023 The first slot tick may come 1..2^DIV_BITS clocks after grant; slot length is HOLD_TICKS ticks, not clocks.
REQ-024 Requests for idle requesters may assert or drop at any time; only grant-time req is evaluated.

Reset
REQ-025 RESET_N low at a rising edge: prescaler=0, state=IDLE, pointer=3, counter=0, grant=0, ack=0, busy=0, tick=0, disp_val=IDLE_CODE.
REQ-026 Reset mid-SHOW aborts the slot with no ack; outputs take reset values the cycle after the edge.

Configuration
REQ-027 Macro DISP_ARBITER_FIXED_PRIO_EN defined: strict fixed priority, requester 0 highest, pointer removed.
REQ-028 Macro undefined: round-robin per REQ-016; every other behaviour is identical in both builds.

Structure
REQ-029 Package disp_arbiter_pkg holds N_REQ=4, CODE_W=3, and the state enum (ST_IDLE, ST_SHOW).
REQ-030 The prescaler is a sub-module tick_prescaler (parameter DIV_BITS, outputs tick); the arbiter and FSM stay in disp_arbiter.

Verification (DIV_BITS=2, HOLD_TICKS=2)
REQ-031 Reset, req=0 -> disp_val=3'b111, grant=0, busy=0; tick every 4 clocks.
REQ-032 req=4'b0001, val[2:0]=3'b010 -> grant=0001 next cycle, disp_val=010, ack[0] pulse at 2nd tick, then one IDLE cycle showing 111.
REQ-033 req=4'b1111 held, distinct vals -> grants 0,1,2,3,0 in order, each slot acked; under FIXED_PRIO_EN only requester 0 is ever granted.
REQ-034 Granted requester 2 drops req after 1 tick -> IDLE next cycle, ack=0, next grant goes to requester 3 if requesting.
REQ-035 RESET_N low for one cycle mid-SHOW -> all outputs at reset values next cycle, no ack, next grant goes to requester 0.
REQ-036 val changed during SHOW -> disp_val unchanged until the slot ends.
